// File: rtl/jump_ctrl_pkg.sv
// Shared constants and helpers for the jump/branch control block.
package jump_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [1:0] BHT_INIT = 2'b01;

    typedef enum logic [2:0] {
        JOP_JUMP  = 3'd0,
        JOP_REG   = 3'd1,
        JOP_BR    = 3'd2,
        JOP_SEQ   = 3'd3,
        JOP_RECOV = 3'd4
    } jop_e;

    // 2-bit saturating counter step toward taken (up) or not-taken
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Bimodal branch history table: 2-bit counters, async read, sync saturating update.
module bht_table
    import jump_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [1:0] cnt [DEPTH];

    // Read returns the stored value; a same-cycle write lands on the next edge
    assign rd_cnt = cnt[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt[i] <= BHT_INIT;
            end
        end else if (wr_en) begin
            cnt[wr_idx] <= sat_step(cnt[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/jump_ctrl_bp.sv
// EX-stage jump/branch resolution with bimodal prediction, flush and statistics.
module jump_ctrl_bp
    import jump_ctrl_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned PRED_MODE = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [31:0]      ex_ins,
    input  logic             ex_zero,
    input  logic             ex_pred_taken,
    output logic [2:0]       jump_op,
    output logic [PC_W-1:0]  recover_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       active;
    logic       is_br;
    logic       br_taken;
    logic       mispred;
    logic [1:0] rd_cnt;
    logic       unused_bits;

    assign opcode     = ex_ins[31:26];
    assign funct      = ex_ins[5:0];
    assign active     = rst && ex_valid && !ex_stall && (ex_ins != 32'd0);
    assign recover_pc = ex_pc + PC_W'(4);
    assign mispred    = is_br && (br_taken != ex_pred_taken);

    // Only the word-index bits of if_pc address the table
    assign unused_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], rd_cnt};

    bht_table #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .wr_en    (is_br),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (br_taken)
    );

    generate
        if (PRED_MODE == 1) begin : g_bimodal
            assign pred_taken = rst && rd_cnt[1];
        end else begin : g_static
            assign pred_taken = 1'b0;
        end
    endgenerate

    // Decode and resolve the EX instruction
    always_comb begin
        jump_op  = JOP_SEQ;
        flush    = 1'b0;
        is_br    = 1'b0;
        br_taken = 1'b0;
        if (active) begin
            case (opcode)
                OP_BEQ: begin
                    is_br    = 1'b1;
                    br_taken = ex_zero;
                end
                OP_BNE: begin
                    is_br    = 1'b1;
                    br_taken = !ex_zero;
                end
                OP_J, OP_JAL: begin
                    jump_op = JOP_JUMP;
                    flush   = 1'b1;
                end
                OP_RTYPE: begin
                    if (funct == FN_JR || funct == FN_JALR) begin
                        jump_op = JOP_REG;
                        flush   = 1'b1;
                    end
                end
                default: ;
            endcase
            if (is_br && (br_taken != ex_pred_taken)) begin
                jump_op = br_taken ? JOP_BR : JOP_RECOV;
                flush   = 1'b1;
            end
        end
    end

    // Saturating statistics
    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (is_br && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispred && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule
